// File: rtl/mem1r1w_fifo_ctrl.sv
// mem1r1w_fifo_ctrl
// Sequences an external 1R1W memory (combinational read, registered write)
// as a circular FIFO with val/rdy enqueue and dequeue interfaces.
// Pointers wrap explicitly at p_num_entries-1, so any depth >= 2 works.
// Reset is asynchronous and active-low on the port named 'reset'.

module mem1r1w_fifo_ctrl #(
  parameter int p_num_entries = 8,
  parameter int p_bit_width   = 5,
  parameter int p_addr_width  = $clog2(p_num_entries)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   enq_val,
  output logic                                   enq_rdy,
  input  logic [p_bit_width-1:0]                 enq_msg,
  output logic                                   deq_val,
  input  logic                                   deq_rdy,
  output logic [p_bit_width-1:0]                 deq_msg,
  output logic                                   mem_write_en,
  output logic [p_addr_width-1:0]                mem_write_addr,
  output logic [p_bit_width-1:0]                 mem_write_data,
  output logic                                   mem_read_en,
  output logic [p_addr_width-1:0]                mem_read_addr,
  input  logic [p_bit_width-1:0]                 mem_read_data,
  output logic [$clog2(p_num_entries+1)-1:0]     count
);

  localparam int c_cnt_w = $clog2(p_num_entries + 1);
  localparam logic [p_addr_width-1:0] c_last_addr = p_addr_width'(p_num_entries - 1);
  localparam logic [c_cnt_w-1:0]      c_full_cnt  = c_cnt_w'(p_num_entries);

  logic [p_addr_width-1:0] wr_ptr;
  logic [p_addr_width-1:0] rd_ptr;
  logic                    full;
  logic                    empty;
  logic                    enq_fire;
  logic                    deq_fire;

  // Occupancy flags come straight from the count register.
  assign full  = (count == c_full_cnt);
  assign empty = (count == '0);

  // Handshake outputs depend only on state, clear and reset; holding reset
  // low forces both sides idle so nothing is accepted or presented.
  assign enq_rdy  = reset && !full && !clear;
  assign deq_val  = reset && !empty && !clear;
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  // Memory port drive: write at the tail on an accepted enqueue, read the
  // head whenever a valid message is presented.
  assign mem_write_en   = enq_fire;
  assign mem_write_addr = wr_ptr;
  assign mem_write_data = enq_msg;
  assign mem_read_en    = deq_val;
  assign mem_read_addr  = rd_ptr;
  assign deq_msg        = deq_val ? mem_read_data : '0;

  // Explicit wrap at the last entry keeps non-power-of-two depths in range.
  function automatic logic [p_addr_width-1:0] next_ptr(input logic [p_addr_width-1:0] ptr);
    next_ptr = (ptr == c_last_addr) ? '0 : ptr + p_addr_width'(1);
  endfunction

  // Pointer and occupancy state; clear flushes without touching memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (deq_fire) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + c_cnt_w'(1);
        2'b01:   count <= count - c_cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // Occupancy must stay within the physical depth.
  a_count_bound : assert property (@(posedge clk) disable iff (!reset) count <= c_full_cnt);

  // Enqueue is never accepted when full, dequeue never taken when empty.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset) !(full && enq_fire));
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset) !(empty && deq_fire));

endmodule
